dct2d_rowcol_ctrl: RTL and testbench
====================================

Name: dct2d_rowcol_ctrl

Overview:
- Sequences one shared 8-point 1-D DCT engine (4-cycle multi-phase core with valid/ready on both sides) to compute a 2-D 8x8 DCT by row-column decomposition.
- Pass 1 forwards 8 input rows through the engine and stores the results in an internal 8x8 transpose buffer.
- Pass 2 feeds the 8 buffer columns through the same engine and streams each result out as one coefficient column.
- Sits between the pixel/level-shift stage and the quantiser.

Parameters:
- IN_W, 32, sample/coefficient width in bits (signed), matches engine IN_W.
- ROW_SHIFT, 0, arithmetic right shift applied to pass-1 results before they are stored (growth control), range 0..8.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input row valid.
- in_ready  out  1  controller accepts input row.
- in_data  in  8*IN_W  input row; sample k at bits [k*IN_W +: IN_W], signed.
- eng_in_valid  out  1  row/column presented to engine.
- eng_in_ready  in  1  engine accepts.
- eng_in_data  out  8*IN_W  engine input, same packing.
- eng_out_valid  in  1  engine result valid.
- eng_out_ready  out  1  controller takes engine result.
- eng_out_data  in  8*IN_W  engine result, same packing.
- out_valid  out  1  coefficient column valid.
- out_ready  in  1  downstream accepts.
- out_data  out  8*IN_W  coefficient column c; element k = Y[k][c].
- out_col  out  3  column index c of out_data.
- out_last  out  1  high with column 7.
- busy  out  1  high when not in S_ROW_FWD with row counter 0.
- blocks_done  out  16  completed-block count, wraps at 65535->0.

Behaviour:
- One clock (clk). Reset rst is asynchronous, active-high.
- While rst is high, all valid/ready outputs are forced to 0.
- Reset values: state S_ROW_FWD, row counter r=0, column counter c=0, out_data=0, out_col=0, blocks_done=0, out_valid=0, busy=0.
- Transpose buffer is not cleared on reset; its contents are don't-care.
- Fire means valid&&ready in the same cycle.
- S_ROW_FWD: combinational pass-through.
  - eng_in_valid=in_valid, in_ready=eng_in_ready, eng_in_data=in_data.
  - On fire -> S_ROW_RES.
- S_ROW_RES: eng_out_ready=1; in_ready=0.
  - On eng_out_valid: tbuf[r][k] <= eng_out_data[k] >>> ROW_SHIFT (sign-preserving, truncating).
  - If r==7: r<=0, c<=0, -> S_COL_ISS. Otherwise r<=r+1, -> S_ROW_FWD.
- S_COL_ISS: eng_in_valid=1, eng_in_data sample k = tbuf[k][c].
  - Data is held stable until fire; on fire -> S_COL_RES.
- S_COL_RES: eng_out_ready=1.
  - On eng_out_valid: out_data<=eng_out_data, out_col<=c, -> S_OUT.
- S_OUT: out_valid=1; out_data, out_col and out_last are held stable while out_ready is low.
  - On fire with c==7: blocks_done++, -> S_ROW_FWD.
  - On fire otherwise: c<=c+1, -> S_COL_ISS.
- Handshake outputs outside their listed states are 0:
  - in_ready only in S_ROW_FWD.
  - eng_in_valid only in S_ROW_FWD/S_COL_ISS.
  - eng_out_ready only in *_RES.
  - out_valid only in S_OUT.
- eng_out_valid outside *_RES is ignored and not acknowledged.
- At most one engine transaction is outstanding; no pass overlap.
- Controller-added latency:
  - 0 cycles input->engine in pass 1.
  - 1 cycle from each engine result capture to the next issue or output.
  - out_valid is asserted the cycle after the column-result capture.
- Next-block input is accepted the cycle after the column-7 output fire, so back-to-back blocks are sustained.
- Reset mid-block aborts immediately and discards the partial block. The first row accepted after reset is row 0. Engine is reset in parallel by the system.
- No arithmetic is performed besides ROW_SHIFT. Widths are unchanged (IN_W in, IN_W out).

Test Plan:
- Identity engine model (out=in, 4-cycle latency), ROW_SHIFT=0, input X[r][k]=8r+k, out_ready=1 -> 8 outputs with out_col 0..7, element k of column c = 8k+c; out_last only on col 7; blocks_done=1.
- ROW_SHIFT=2, all inputs = -13 -> every output element = -4 (arithmetic shift floor); no positive values appear.
- Pass-2 backpressure: out_ready low for 10 cycles at column 3 -> out_data/out_col=3 stable; eng_in_valid=0; in_ready=0 throughout; resumes with column 4 after release.
- Engine stalls: eng_in_ready low 6 cycles in pass 1 -> in_ready low, no row skipped. eng_out_valid pulse injected in S_OUT -> eng_out_ready=0, state unchanged.
- rst pulse after row 5 accepted -> all valids/readies 0 during reset, blocks_done=0. New block X'[r][k]=k -> column c elements all = c (old rows discarded).
- Two back-to-back blocks -> in_ready=1 exactly one cycle after column-7 fire; blocks_done=2. Preload blocks_done 65535 via 65535 identity blocks (or force) -> wraps to 0.

Source files
------------

// File: rtl/dct2d_rowcol_ctrl.sv
// 2-D 8x8 DCT controller: row-column decomposition around one shared 1-D engine.
// Pass 1 forwards input rows to the engine and stores the (optionally shifted)
// results row-wise in a transpose buffer. Pass 2 reads that buffer column-wise,
// sends each column through the engine and streams the result out.
module dct2d_rowcol_ctrl #(
  parameter int IN_W      = 32,
  parameter int ROW_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8*IN_W-1:0] in_data,
  output logic              eng_in_valid,
  input  logic              eng_in_ready,
  output logic [8*IN_W-1:0] eng_in_data,
  input  logic              eng_out_valid,
  output logic              eng_out_ready,
  input  logic [8*IN_W-1:0] eng_out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8*IN_W-1:0] out_data,
  output logic [2:0]        out_col,
  output logic              out_last,
  output logic              busy,
  output logic [15:0]       blocks_done
);

  typedef enum logic [2:0] {
    S_ROW_FWD = 3'd0,
    S_ROW_RES = 3'd1,
    S_COL_ISS = 3'd2,
    S_COL_RES = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  state_t              r_state;
  logic [2:0]          r_row;
  logic [2:0]          r_col;
  logic [8*IN_W-1:0]   r_out_data;
  logic [2:0]          r_out_col;
  logic                r_out_last;
  logic [15:0]         r_blocks_done;

  // Transpose buffer: written one row per pass-1 result, read one column per pass-2 issue.
  logic [IN_W-1:0]     r_tbuf [0:7][0:7];

  logic [8*IN_W-1:0]   w_row_shifted;
  logic [8*IN_W-1:0]   w_col_data;
  logic                w_fwd;
  logic                w_iss;
  logic                w_res;
  logic                w_out;

  // Per-lane shift of pass-1 results and column gather for pass-2 issue.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic signed [IN_W-1:0] w_res_el;
      assign w_res_el                       = eng_out_data[gi*IN_W +: IN_W];
      assign w_row_shifted[gi*IN_W +: IN_W] = w_res_el >>> ROW_SHIFT;
      assign w_col_data[gi*IN_W +: IN_W]    = r_tbuf[gi][r_col];
    end
  endgenerate

  assign w_fwd = (r_state == S_ROW_FWD);
  assign w_iss = (r_state == S_COL_ISS);
  assign w_res = (r_state == S_ROW_RES) || (r_state == S_COL_RES);
  assign w_out = (r_state == S_OUT);

  // Handshakes are decoded from the state; reset gates them all low because the
  // pass-1 path is a combinational pass-through of the engine/input handshakes.
  assign in_ready      = !rst && w_fwd && eng_in_ready;
  assign eng_in_valid  = !rst && ((w_fwd && in_valid) || w_iss);
  assign eng_in_data   = w_iss ? w_col_data : in_data;
  assign eng_out_ready = !rst && w_res;
  assign out_valid     = !rst && w_out;
  assign out_data      = r_out_data;
  assign out_col       = r_out_col;
  assign out_last      = r_out_last;
  assign busy          = !(w_fwd && (r_row == 3'd0));
  assign blocks_done   = r_blocks_done;

  // Store each pass-1 result as a buffer row; the buffer has no reset.
  always_ff @(posedge clk) begin
    if ((r_state == S_ROW_RES) && eng_out_valid) begin
      for (int k = 0; k < 8; k++) begin
        r_tbuf[r_row][k] <= w_row_shifted[k*IN_W +: IN_W];
      end
    end
  end

  // Sequencer: row forward/result, column issue/result, output hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_ROW_FWD;
      r_row         <= 3'd0;
      r_col         <= 3'd0;
      r_out_data    <= '0;
      r_out_col     <= 3'd0;
      r_out_last    <= 1'b0;
      r_blocks_done <= 16'd0;
    end else begin
      case (r_state)
        S_ROW_FWD: begin
          if (in_valid && eng_in_ready) r_state <= S_ROW_RES;
        end
        S_ROW_RES: begin
          if (eng_out_valid) begin
            if (r_row == 3'd7) begin
              r_row   <= 3'd0;
              r_col   <= 3'd0;
              r_state <= S_COL_ISS;
            end else begin
              r_row   <= r_row + 3'd1;
              r_state <= S_ROW_FWD;
            end
          end
        end
        S_COL_ISS: begin
          if (eng_in_ready) r_state <= S_COL_RES;
        end
        S_COL_RES: begin
          if (eng_out_valid) begin
            r_out_data <= eng_out_data;
            r_out_col  <= r_col;
            r_out_last <= (r_col == 3'd7);
            r_state    <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_last <= 1'b0;
            if (r_col == 3'd7) begin
              r_col         <= 3'd0;
              r_blocks_done <= r_blocks_done + 16'd1;
              r_state       <= S_ROW_FWD;
            end else begin
              r_col   <= r_col + 3'd1;
              r_state <= S_COL_ISS;
            end
          end
        end
        default: r_state <= S_ROW_FWD;
      endcase
    end
  end

endmodule

// File: tb/tb_dct2d_rowcol_ctrl.sv
// Bench for dct2d_rowcol_ctrl: two instances (ROW_SHIFT 0 and 2) share one
// identity engine model; expected columns are queued when a block is pushed.
`timescale 1ns/1ps
module tb_dct2d_rowcol_ctrl;
  localparam int IN_W = 32;
  localparam int DW   = 8 * IN_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          eng_in_ready;
  logic          eng_out_valid;
  logic [DW-1:0] eng_out_data0, eng_out_data2;
  logic          out_ready;

  logic          in_ready0, eng_in_valid0, eng_out_ready0, out_valid0, out_last0, busy0;
  logic [DW-1:0] eng_in_data0, out_data0;
  logic [2:0]    out_col0;
  logic [15:0]   blocks_done0;
  logic          in_ready2, eng_in_valid2, eng_out_ready2, out_valid2, out_last2, busy2;
  logic [DW-1:0] eng_in_data2, out_data2;
  logic [2:0]    out_col2;
  logic [15:0]   blocks_done2;

  always #5 clk = ~clk;

  dct2d_rowcol_ctrl #(.IN_W(IN_W), .ROW_SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .eng_in_valid(eng_in_valid0), .eng_in_ready(eng_in_ready), .eng_in_data(eng_in_data0),
    .eng_out_valid(eng_out_valid), .eng_out_ready(eng_out_ready0), .eng_out_data(eng_out_data0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_col(out_col0),
    .out_last(out_last0), .busy(busy0), .blocks_done(blocks_done0)
  );

  dct2d_rowcol_ctrl #(.IN_W(IN_W), .ROW_SHIFT(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .eng_in_valid(eng_in_valid2), .eng_in_ready(eng_in_ready), .eng_in_data(eng_in_data2),
    .eng_out_valid(eng_out_valid), .eng_out_ready(eng_out_ready2), .eng_out_data(eng_out_data2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_col(out_col2),
    .out_last(out_last2), .busy(busy2), .blocks_done(blocks_done2)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [2:0]    col;
    logic          last;
  } exp_t;

  exp_t          exp0_q[$];
  exp_t          exp2_q[$];
  logic [DW-1:0] src_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Engine model and stimulus control state
  bit            eng_busy = 0;
  int            eng_cnt = 0;
  logic [DW-1:0] eng_d0 = '0, eng_d2 = '0;
  int            stall_cnt = 0;
  bit            inject = 0, inject_req = 0;
  int            hold_cnt = 0, hold_col = 3, hold_seen = 0;
  logic [DW-1:0] held_data = '0;
  bit            b2b_mode = 0, b2b_next = 0;
  int            b2b_seen = 0;

  // Per-cycle samples taken just before the active edge
  bit            s_in_fire, s_ein_fire, s_eout_fire, s_o_fire, s_last_fire;
  logic [DW-1:0] s_eid0, s_eid2;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic int x_val(input int mode, input int r, input int k);
    case (mode)
      0: return 8 * r + k;
      1: return -13;
      2: return k;
      default: return 99;
    endcase
  endfunction

  task automatic drive();
    in_valid      = (src_q.size() > 0);
    in_data       = (src_q.size() > 0) ? src_q[0] : '0;
    eng_in_ready  = !eng_busy && (stall_cnt == 0);
    eng_out_valid = (eng_busy && (eng_cnt == 0)) || inject;
    eng_out_data0 = eng_d0;
    eng_out_data2 = eng_d2;
    out_ready     = !((hold_cnt > 0) && out_valid0 && (out_col0 == hold_col[2:0]));
  endtask

  task automatic push_block(input int mode, input bit with_exp);
    logic [DW-1:0] row;
    exp_t e0, e2;
    int v;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) row[k*IN_W +: IN_W] = x_val(mode, r, k);
      src_q.push_back(row);
    end
    if (with_exp) begin
      for (int c = 0; c < 8; c++) begin
        for (int k = 0; k < 8; k++) begin
          v = x_val(mode, k, c);
          e0.d[k*IN_W +: IN_W] = v;
          e2.d[k*IN_W +: IN_W] = v >>> 2;
        end
        e0.col = c[2:0]; e0.last = (c == 7);
        e2.col = c[2:0]; e2.last = (c == 7);
        exp0_q.push_back(e0);
        exp2_q.push_back(e2);
      end
    end
    drive();
  endtask

  task automatic step();
    exp_t e0, e2;
    @(negedge clk);
    s_in_fire   = in_valid && in_ready0;
    s_ein_fire  = eng_in_valid0 && eng_in_ready;
    s_eout_fire = eng_out_valid && eng_out_ready0 && eng_busy && (eng_cnt == 0);
    s_o_fire    = out_valid0 && out_ready;
    s_last_fire = s_o_fire && out_last0;
    s_eid0      = eng_in_data0;
    s_eid2      = eng_in_data2;
    if (stall_cnt > 0 && in_valid) check("stall_in_ready", DW'(in_ready0), DW'(0));
    if (inject) begin
      check("inject_eng_out_ready", DW'(eng_out_ready0), DW'(0));
      check("inject_out_valid", DW'(out_valid0), DW'(1));
    end
    if (out_valid0 && !out_ready) begin
      if (hold_seen == 0) begin
        held_data  = out_data0;
        inject_req = 1;
      end
      check("hold_data", out_data0, held_data);
      check("hold_col", DW'(out_col0), DW'(hold_col));
      check("hold_eng_in_valid", DW'(eng_in_valid0), DW'(0));
      check("hold_in_ready", DW'(in_ready0), DW'(0));
      hold_seen++;
      hold_cnt--;
    end
    if (b2b_next) begin
      check("b2b_in_ready_after", DW'(in_ready0), DW'(1));
      b2b_next = 0;
    end
    if (b2b_mode && s_last_fire && src_q.size() > 0) begin
      check("b2b_in_ready_at_fire", DW'(in_ready0), DW'(0));
      b2b_next = 1;
      b2b_seen++;
    end
    if (s_o_fire) begin
      check("out_expected", DW'(exp0_q.size() != 0), DW'(1));
      if (exp0_q.size() != 0 && exp2_q.size() != 0) begin
        e0 = exp0_q.pop_front();
        e2 = exp2_q.pop_front();
        check("out_data_s0", out_data0, e0.d);
        check("out_col", DW'(out_col0), DW'(e0.col));
        check("out_last", DW'(out_last0), DW'(e0.last));
        check("out_data_s2", out_data2, e2.d);
        $display("out col=%0d last=%0b elem0=%0d elem7=%0d", out_col0, out_last0,
                 $signed(out_data0[0 +: IN_W]), $signed(out_data0[7*IN_W +: IN_W]));
      end
    end
    @(posedge clk);
    #1;
    if (s_in_fire) void'(src_q.pop_front());
    if (s_eout_fire) eng_busy = 0;
    else if (eng_busy && eng_cnt > 0) eng_cnt--;
    if (s_ein_fire) begin
      eng_busy = 1;
      eng_cnt  = 3;
      eng_d0   = s_eid0;
      eng_d2   = s_eid2;
    end
    if (stall_cnt > 0) stall_cnt--;
    inject     = inject_req;
    inject_req = 0;
    drive();
  endtask

  task automatic run_idle(input int budget, input string tag);
    int n = 0;
    while ((exp0_q.size() > 0 || src_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_in_time"}, DW'(n < budget), DW'(1));
  endtask

  task automatic do_reset(input int cycles);
    rst = 1;
    src_q.delete(); exp0_q.delete(); exp2_q.delete();
    eng_busy = 0; eng_cnt = 0; inject = 0; inject_req = 0;
    stall_cnt = 0; hold_cnt = 0; b2b_next = 0;
    in_valid = 1; in_data = '1; eng_in_ready = 1; eng_out_valid = 1; out_ready = 1;
    repeat (cycles) begin
      @(negedge clk);
      check("rst_in_ready", DW'(in_ready0), DW'(0));
      check("rst_eng_in_valid", DW'(eng_in_valid0), DW'(0));
      check("rst_eng_out_ready", DW'(eng_out_ready0), DW'(0));
      check("rst_out_valid", DW'(out_valid0), DW'(0));
      check("rst_busy", DW'(busy0), DW'(0));
      check("rst_blocks_done", DW'(blocks_done0), DW'(0));
      check("rst_out_col", DW'(out_col0), DW'(0));
      check("rst_out_data", out_data0, DW'(0));
    end
    @(posedge clk);
    #1;
    rst = 0;
    drive();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nf, n;
    rst = 1;
    do_reset(3);

    // Ramp block: column c element k = 8k+c
    check("idle_busy", DW'(busy0), DW'(0));
    push_block(0, 1);
    step();
    check("busy_after_first_row", DW'(busy0), DW'(1));
    run_idle(600, "ramp");
    check("blocks_after_ramp", DW'(blocks_done0), DW'(1));
    check("idle_busy_after", DW'(busy0), DW'(0));

    // Constant -13: shift-2 instance must floor to -4
    push_block(1, 1);
    run_idle(600, "neg");
    check("blocks_after_neg", DW'(blocks_done0), DW'(2));

    // Output backpressure at column 3 with a stray engine-valid pulse
    hold_col = 3; hold_cnt = 10; hold_seen = 0;
    push_block(0, 1);
    run_idle(600, "hold");
    check("hold_cycles", DW'(hold_seen), DW'(10));

    // Engine input stall at the start of pass 1
    stall_cnt = 6;
    push_block(0, 1);
    run_idle(600, "stall");
    check("blocks_after_stall", DW'(blocks_done0), DW'(4));

    // Reset after row 5 is accepted; partial block is discarded
    push_block(3, 0);
    nf = 0; n = 0;
    while (nf < 6 && n < 200) begin
      step();
      if (s_in_fire) nf++;
      n++;
    end
    check("rows_before_rst", DW'(nf), DW'(6));
    do_reset(2);

    // Two back-to-back blocks, the first being X'[r][k]=k
    b2b_mode = 1; b2b_seen = 0;
    push_block(2, 1);
    push_block(0, 1);
    run_idle(1200, "b2b");
    b2b_mode = 0;
    check("b2b_seen", DW'(b2b_seen), DW'(1));
    check("blocks_after_b2b", DW'(blocks_done0), DW'(2));

    // Counter wrap from 65535
    force u_dut0.r_blocks_done = 16'hffff;
    force u_dut2.r_blocks_done = 16'hffff;
    #1;
    release u_dut0.r_blocks_done;
    release u_dut2.r_blocks_done;
    check("wrap_preload", DW'(blocks_done0), DW'(16'hffff));
    push_block(0, 1);
    run_idle(600, "wrap");
    check("wrap_s0", DW'(blocks_done0), DW'(0));
    check("wrap_s2", DW'(blocks_done2), DW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
